// File: rtl/legv8_ctrl_pkg.sv
// Shared types and opcode constants for the LEGv8 multicycle control sequencer.
// Holds the FSM state encoding, datapath select encodings and the B.cond evaluator.
package legv8_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        EXT_DADDR9 = 2'd0,
        EXT_COND19 = 2'd1,
        EXT_BR26   = 2'd2,
        EXT_IMM12  = 2'd3
    } ext_sel_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_COND   = 2'd1,
        PC_BRANCH = 2'd2
    } pc_sel_t;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'd0,
        ALU_SUB    = 3'd1,
        ALU_AND    = 3'd2,
        ALU_PASS_B = 3'd3
    } alu_op_t;

    typedef enum logic [3:0] {
        CLS_ADDI,
        CLS_ADDS,
        CLS_SUBS,
        CLS_AND,
        CLS_LDUR,
        CLS_STUR,
        CLS_B,
        CLS_BCOND,
        CLS_CBZ,
        CLS_ILLEGAL
    } instr_class_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    // Opcode fields, left-aligned at instruction bit 31.
    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [10:0] OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] OP_SUBS  = 11'b11101011000;
    localparam logic [10:0] OP_AND   = 11'b10001010000;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;

    localparam logic [3:0]  COND_EQ  = 4'b0000;
    localparam logic [3:0]  COND_LT  = 4'b1011;

    // Only EQ and LT can ever be taken; every other condition falls through.
    function automatic logic cond_taken(input logic [3:0] cond, input nzcv_t f);
        case (cond)
            COND_EQ: return f.z;
            COND_LT: return f.n ^ f.v;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/legv8_instr_classify.sv
// Combinational opcode classifier: maps the top 11 instruction bits to an
// instruction class and flags anything outside the supported subset.
module legv8_instr_classify
    import legv8_ctrl_pkg::*;
(
    input  logic [10:0]  opc,
    output instr_class_t cls,
    output logic         is_illegal
);

    always_comb begin
        cls = CLS_ILLEGAL;
        if (opc[10:1] == OP_ADDI) begin
            cls = CLS_ADDI;
        end else if (opc == OP_ADDS) begin
            cls = CLS_ADDS;
        end else if (opc == OP_SUBS) begin
            cls = CLS_SUBS;
        end else if (opc == OP_AND) begin
            cls = CLS_AND;
        end else if (opc == OP_LDUR) begin
            cls = CLS_LDUR;
        end else if (opc == OP_STUR) begin
            cls = CLS_STUR;
        end else if (opc[10:5] == OP_B) begin
            cls = CLS_B;
        end else if (opc[10:3] == OP_BCOND) begin
            cls = CLS_BCOND;
        end else if (opc[10:3] == OP_CBZ) begin
            cls = CLS_CBZ;
        end
        is_illegal = (cls == CLS_ILLEGAL);
    end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// LEGv8 multicycle control sequencer: fetch handshake, decode, EXEC/MEM/WB
// sequencing of the shared datapath, plus the NZCV flag register for B.cond.
module legv8_multicycle_ctrl
    import legv8_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    output logic        instr_req,
    input  logic        instr_ack,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        alu_neg,
    input  logic        alu_ovf,
    input  logic        alu_carry,
    output logic [1:0]  ext_sel,
    output logic        alu_src,
    output logic [2:0]  alu_op,
    output logic        reg2_loc,
    output logic        dmem_rd,
    output logic        dmem_wr,
    input  logic        dmem_ack,
    output logic        mem_to_reg,
    output logic        reg_wr,
    output logic        pc_wr,
    output logic [1:0]  pc_sel,
    output logic        illegal
);

    state_t       state_q, state_d;
    logic [31:0]  ir_q, ir_d;
    nzcv_t        nzcv_q, nzcv_d;

    instr_class_t cls;
    logic         cls_illegal;

    ext_sel_t     ext_dec;
    logic         alu_src_dec;
    alu_op_t      alu_op_dec;
    logic         reg2_dec;
    logic         in_instr;

    // Operand fields go to the datapath directly; carry is kept in NZCV but no
    // supported condition reads it.
    logic         ctrl_bits_unused;
    assign ctrl_bits_unused = ^{ir_q[20:4], nzcv_q.c};

    legv8_instr_classify u_classify (
        .opc        (ir_q[31:21]),
        .cls        (cls),
        .is_illegal (cls_illegal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            nzcv_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            nzcv_q  <= nzcv_d;
        end
    end

    // Per-instruction datapath selects; depend only on the latched IR so they
    // hold steady for the whole instruction.
    always_comb begin
        ext_dec     = EXT_DADDR9;
        alu_src_dec = 1'b0;
        alu_op_dec  = ALU_ADD;
        reg2_dec    = 1'b0;
        case (cls)
            CLS_ADDI: begin
                ext_dec     = EXT_IMM12;
                alu_src_dec = 1'b1;
            end
            CLS_SUBS:  alu_op_dec = ALU_SUB;
            CLS_AND:   alu_op_dec = ALU_AND;
            CLS_LDUR:  alu_src_dec = 1'b1;
            CLS_STUR: begin
                alu_src_dec = 1'b1;
                reg2_dec    = 1'b1;
            end
            CLS_B:     ext_dec = EXT_BR26;
            CLS_BCOND: ext_dec = EXT_COND19;
            CLS_CBZ: begin
                ext_dec    = EXT_COND19;
                alu_op_dec = ALU_PASS_B;
                reg2_dec   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        nzcv_d     = nzcv_q;
        instr_req  = 1'b0;
        ext_sel    = EXT_DADDR9;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        reg2_loc   = 1'b0;
        dmem_rd    = 1'b0;
        dmem_wr    = 1'b0;
        mem_to_reg = 1'b0;
        reg_wr     = 1'b0;
        pc_wr      = 1'b0;
        pc_sel     = PC_PLUS4;
        illegal    = 1'b0;

        in_instr = (state_q == ST_DECODE) || (state_q == ST_EXEC) ||
                   (state_q == ST_MEM)    || (state_q == ST_WB);
        if (in_instr && !cls_illegal) begin
            ext_sel  = ext_dec;
            alu_src  = alu_src_dec;
            alu_op   = alu_op_dec;
            reg2_loc = reg2_dec;
        end

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                instr_req = 1'b1;
                if (instr_ack) begin
                    ir_d    = instr;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = cls_illegal ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                case (cls)
                    CLS_ADDI, CLS_AND: state_d = ST_WB;
                    CLS_ADDS, CLS_SUBS: begin
                        nzcv_d.n = alu_neg;
                        nzcv_d.z = alu_zero;
                        nzcv_d.c = alu_carry;
                        nzcv_d.v = alu_ovf;
                        state_d  = ST_WB;
                    end
                    CLS_LDUR, CLS_STUR: state_d = ST_MEM;
                    CLS_B: begin
                        pc_wr   = 1'b1;
                        pc_sel  = PC_BRANCH;
                        state_d = ST_FETCH;
                    end
                    CLS_BCOND: begin
                        pc_wr   = 1'b1;
                        pc_sel  = cond_taken(ir_q[3:0], nzcv_q) ? PC_COND : PC_PLUS4;
                        state_d = ST_FETCH;
                    end
                    CLS_CBZ: begin
                        pc_wr   = 1'b1;
                        pc_sel  = alu_zero ? PC_COND : PC_PLUS4;
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                if (cls == CLS_LDUR) begin
                    dmem_rd = 1'b1;
                    if (dmem_ack) state_d = ST_WB;
                end else begin
                    dmem_wr = 1'b1;
                    // Stores retire here: no writeback cycle follows.
                    if (dmem_ack) begin
                        pc_wr   = 1'b1;
                        pc_sel  = PC_PLUS4;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                reg_wr     = 1'b1;
                mem_to_reg = (cls == CLS_LDUR);
                pc_wr      = 1'b1;
                pc_sel     = PC_PLUS4;
                state_d    = ST_FETCH;
            end
            ST_TRAP: begin
                illegal = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Self-checking bench for legv8_multicycle_ctrl: directed vector table, random
// instruction stream against a transaction-level model, and reset/trap corners.
`timescale 1ns/1ps
module tb_legv8_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic        instr_ack = 1'b0;
    logic [31:0] instr = '0;
    logic        alu_zero = 1'b0, alu_neg = 1'b0, alu_ovf = 1'b0, alu_carry = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        instr_req, alu_src, reg2_loc, dmem_rd, dmem_wr, mem_to_reg, reg_wr, pc_wr, illegal;
    logic [1:0]  ext_sel, pc_sel;
    logic [2:0]  alu_op;
    logic [15:0] outs;

    int nchk = 0;
    int nerr = 0;
    logic [3:0] m_nzcv;

    always #5 clk = ~clk;

    legv8_multicycle_ctrl dut (
        .clk(clk), .reset_n(reset_n), .run(run),
        .instr_req(instr_req), .instr_ack(instr_ack), .instr(instr),
        .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_ovf(alu_ovf), .alu_carry(alu_carry),
        .ext_sel(ext_sel), .alu_src(alu_src), .alu_op(alu_op), .reg2_loc(reg2_loc),
        .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_ack(dmem_ack),
        .mem_to_reg(mem_to_reg), .reg_wr(reg_wr), .pc_wr(pc_wr), .pc_sel(pc_sel),
        .illegal(illegal)
    );

    assign outs = {instr_req, ext_sel, alu_src, alu_op, reg2_loc, dmem_rd, dmem_wr,
                   mem_to_reg, reg_wr, pc_wr, pc_sel, illegal};

    typedef struct {
        int cycles;  int pc_wr_n; int pc_sel; int reg_wr_n; int m2r;
        int rd_n;    int wr_n;    int ext;    int alu_src;  int alu_op;
        int reg2_dec; int reg2_end;
        bit ext_stable; bit trapped; bit timeout;
        bit c_ext; bit c_src; bit c_op; bit c_r2d; bit c_r2e;
    } obs_t;

    typedef struct {
        logic [31:0] ins; int fw; int mw; logic [3:0] fl;
        int cycles; int pc_sel; int reg_wr_n; int rd_n; int wr_n; int m2r; int ext;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Runs one instruction starting in the cycle the DUT requests a fetch.
    // fw/mw are wait cycles before the fetch/memory ack; fl = {n,z,c,v} ALU flags.
    task automatic do_instr(input logic [31:0] ins, input int fw, input int mw,
                            input logic [3:0] fl, input bit stray, output obs_t o);
        int  reqs = 0;
        int  mems = 0;
        int  dec_at = -1;
        bit  done = 0;
        o = '{default: 0};
        o.ext_stable = 1;
        instr = ins;
        {alu_neg, alu_zero, alu_carry, alu_ovf} = fl;
        while (!done) begin
            if (o.cycles >= 60) begin
                o.timeout = 1;
                break;
            end
            instr_ack = instr_req ? (reqs == fw) : (stray && (($urandom & 1) != 0));
            dmem_ack  = (dmem_rd || dmem_wr) ? (mems == mw) : (stray && (($urandom & 1) != 0));
            @(negedge clk);
            o.cycles++;
            if (instr_req) begin
                if (instr_ack) dec_at = o.cycles + 1;
                reqs++;
            end
            if (dmem_rd || dmem_wr) mems++;
            if (o.cycles == dec_at) begin
                o.ext = ext_sel;
                o.alu_src = alu_src;
                o.reg2_dec = reg2_loc;
            end else if (dec_at > 0 && o.cycles > dec_at &&
                         (int'(ext_sel) != o.ext || int'(alu_src) != o.alu_src)) begin
                o.ext_stable = 0;
            end
            if (dec_at > 0 && o.cycles == dec_at + 1) o.alu_op = alu_op;
            if (dmem_rd) o.rd_n++;
            if (dmem_wr) o.wr_n++;
            if (reg_wr) begin
                o.reg_wr_n++;
                o.m2r = mem_to_reg;
            end
            if (pc_wr) begin
                o.pc_wr_n++;
                o.pc_sel = pc_sel;
                o.reg2_end = reg2_loc;
                done = 1;
            end
            if (illegal) begin
                o.trapped = 1;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        instr_ack = 1'b0;
        dmem_ack  = 1'b0;
    endtask

    // Reference: what a whole instruction must look like from the outside.
    task automatic model(input logic [31:0] ins, input int fw, input int mw,
                         input logic [3:0] fl, output obs_t e);
        e = '{default: 0};
        e.pc_wr_n = 1;
        e.ext_stable = 1;
        if (ins[31:22] == 10'b1001000100) begin
            e.cycles = 4 + fw; e.reg_wr_n = 1; e.ext = 3; e.alu_src = 1; e.alu_op = 0;
            e.c_ext = 1; e.c_src = 1; e.c_op = 1;
        end else if (ins[31:21] == 11'b10101011000 || ins[31:21] == 11'b11101011000 ||
                     ins[31:21] == 11'b10001010000) begin
            e.cycles = 4 + fw; e.reg_wr_n = 1; e.alu_src = 0; e.reg2_dec = 0;
            e.alu_op = (ins[31:21] == 11'b11101011000) ? 1 :
                       (ins[31:21] == 11'b10001010000) ? 2 : 0;
            e.c_src = 1; e.c_op = 1; e.c_r2d = 1;
            if (ins[31:21] != 11'b10001010000) m_nzcv = fl;
        end else if (ins[31:21] == 11'b11111000010) begin
            e.cycles = 5 + fw + mw; e.reg_wr_n = 1; e.m2r = 1; e.rd_n = mw + 1;
            e.ext = 0; e.alu_src = 1; e.alu_op = 0; e.c_ext = 1; e.c_src = 1; e.c_op = 1;
        end else if (ins[31:21] == 11'b11111000000) begin
            e.cycles = 4 + fw + mw; e.wr_n = mw + 1;
            e.ext = 0; e.alu_src = 1; e.alu_op = 0; e.c_ext = 1; e.c_src = 1; e.c_op = 1;
        end else if (ins[31:26] == 6'b000101) begin
            e.cycles = 3 + fw; e.pc_sel = 2; e.ext = 2; e.c_ext = 1;
        end else if (ins[31:24] == 8'b01010100) begin
            e.cycles = 3 + fw; e.ext = 1; e.c_ext = 1;
            if (ins[3:0] == 4'b0000)      e.pc_sel = m_nzcv[2] ? 1 : 0;
            else if (ins[3:0] == 4'b1011) e.pc_sel = (m_nzcv[3] != m_nzcv[0]) ? 1 : 0;
            else                          e.pc_sel = 0;
        end else begin
            e.cycles = 3 + fw; e.ext = 1; e.pc_sel = fl[2] ? 1 : 0;
            e.alu_op = 3; e.reg2_end = 1; e.c_ext = 1; e.c_op = 1; e.c_r2e = 1;
        end
    endtask

    task automatic compare(input string tag, input obs_t a, input obs_t e);
        chk({tag, " timeout"}, a.timeout, 0);
        chk({tag, " cycles"}, a.cycles, e.cycles);
        chk({tag, " pc_wr count"}, a.pc_wr_n, e.pc_wr_n);
        chk({tag, " pc_sel"}, a.pc_sel, e.pc_sel);
        chk({tag, " reg_wr count"}, a.reg_wr_n, e.reg_wr_n);
        chk({tag, " dmem_rd cycles"}, a.rd_n, e.rd_n);
        chk({tag, " dmem_wr cycles"}, a.wr_n, e.wr_n);
        chk({tag, " ext/alu_src stable"}, a.ext_stable, 1);
        if (e.reg_wr_n != 0) chk({tag, " mem_to_reg"}, a.m2r, e.m2r);
        if (e.c_ext) chk({tag, " ext_sel"}, a.ext, e.ext);
        if (e.c_src) chk({tag, " alu_src"}, a.alu_src, e.alu_src);
        if (e.c_op)  chk({tag, " alu_op"}, a.alu_op, e.alu_op);
        if (e.c_r2d) chk({tag, " reg2_loc decode"}, a.reg2_dec, e.reg2_dec);
        if (e.c_r2e) chk({tag, " reg2_loc exec"}, a.reg2_end, e.reg2_end);
    endtask

    task automatic start_run();
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk); #1 run = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [3:0]  cond;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 8);
        case ($urandom_range(0, 2))
            0:       cond = 4'b0000;
            1:       cond = 4'b1011;
            default: cond = r[3:0];
        endcase
        case (k)
            0: return {10'b1001000100, r[21:0]};
            1: return {11'b10101011000, r[20:0]};
            2: return {11'b11101011000, r[20:0]};
            3: return {11'b10001010000, r[20:0]};
            4: return {11'b11111000010, r[20:0]};
            5: return {11'b11111000000, r[20:0]};
            6: return {6'b000101, r[25:0]};
            7: return {8'b01010100, r[23:4], cond};
            default: return {8'b10110100, r[23:0]};
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   vt[16];
        obs_t   o, e;
        int     k, nreq, nill, npc;
        logic [31:0] ins;
        int     fw, mw;
        logic [3:0] fl;

        //            ins           fw mw fl       cyc pcs rw rd wr m2r ext
        vt[0]  = '{32'h910017E1, 0, 0, 4'b0000, 4, 0, 1, 0, 0, 0, 3};
        vt[1]  = '{32'hF8408022, 0, 2, 4'b0000, 7, 0, 1, 3, 0, 1, 0};
        vt[2]  = '{32'hEB030041, 0, 0, 4'b1000, 4, 0, 1, 0, 0, 0, -1};
        vt[3]  = '{32'h5400004B, 1, 0, 4'b0000, 4, 1, 0, 0, 0, 0, 1};
        vt[4]  = '{32'hEB030041, 0, 0, 4'b1001, 4, 0, 1, 0, 0, 0, -1};
        vt[5]  = '{32'h5400004B, 0, 0, 4'b0000, 3, 0, 0, 0, 0, 0, 1};
        vt[6]  = '{32'hB4000083, 0, 0, 4'b0100, 3, 1, 0, 0, 0, 0, 1};
        vt[7]  = '{32'hB4000083, 0, 0, 4'b0000, 3, 0, 0, 0, 0, 0, 1};
        vt[8]  = '{32'h14000010, 0, 0, 4'b0000, 3, 2, 0, 0, 0, 0, 2};
        vt[9]  = '{32'hF8008022, 2, 1, 4'b0000, 7, 0, 0, 0, 2, 0, 0};
        vt[10] = '{32'h8A030041, 0, 0, 4'b0000, 4, 0, 1, 0, 0, 0, -1};
        vt[11] = '{32'hAB030041, 0, 0, 4'b0100, 4, 0, 1, 0, 0, 0, -1};
        vt[12] = '{32'h54000040, 0, 0, 4'b0000, 3, 1, 0, 0, 0, 0, 1};
        vt[13] = '{32'h54000041, 0, 0, 4'b0000, 3, 0, 0, 0, 0, 0, 1};
        vt[14] = '{32'hEB030041, 0, 0, 4'b0001, 4, 0, 1, 0, 0, 0, -1};
        vt[15] = '{32'h5400004B, 0, 0, 4'b0000, 3, 1, 0, 0, 0, 0, 1};

        // Reset state and IDLE behaviour
        repeat (2) @(negedge clk);
        chk("reset outputs", outs, 16'h0);
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle without run", outs, 16'h0);
        end
        start_run();

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            do_instr(vt[i].ins, vt[i].fw, vt[i].mw, vt[i].fl, 1'b0, o);
            chk($sformatf("vec%0d timeout", i), o.timeout, 0);
            chk($sformatf("vec%0d cycles", i), o.cycles, vt[i].cycles);
            chk($sformatf("vec%0d pc_wr count", i), o.pc_wr_n, 1);
            chk($sformatf("vec%0d pc_sel", i), o.pc_sel, vt[i].pc_sel);
            chk($sformatf("vec%0d reg_wr count", i), o.reg_wr_n, vt[i].reg_wr_n);
            chk($sformatf("vec%0d dmem_rd cycles", i), o.rd_n, vt[i].rd_n);
            chk($sformatf("vec%0d dmem_wr cycles", i), o.wr_n, vt[i].wr_n);
            chk($sformatf("vec%0d mem_to_reg", i), o.m2r, vt[i].m2r);
            if (vt[i].ext >= 0) chk($sformatf("vec%0d ext_sel", i), o.ext, vt[i].ext);
            if (vt[i].ins == 32'h910017E1) chk("vec addi alu_src", o.alu_src, 1);
            if (vt[i].ins[31:24] == 8'hB4) chk($sformatf("vec%0d cbz reg2_loc", i), o.reg2_end, 1);
        end

        // Reset while a STUR waits in MEM
        instr = 32'hF8008022;
        instr_ack = 1'b1;
        k = 0;
        while (!dmem_wr && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        chk("stur reached MEM", (k < 10), 1);
        instr_ack = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk("async reset clears outputs", outs, 16'h0);
        repeat (3) begin
            @(negedge clk);
            chk("no strobes in reset", {dmem_wr, pc_wr, reg_wr}, 3'b000);
        end
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        chk("idle after reset", outs, 16'h0);
        m_nzcv = 4'b0000;
        start_run();

        // Random instruction stream against the reference model
        for (int i = 0; i < 150; i++) begin
            ins = rand_instr();
            fw  = $urandom_range(0, 3);
            mw  = $urandom_range(0, 3);
            fl  = 4'($urandom_range(0, 15));
            model(ins, fw, mw, fl, e);
            do_instr(ins, fw, mw, fl, 1'b1, o);
            compare($sformatf("rand%0d %h", i, ins), o, e);
        end

        // Undecodable opcode traps for good
        do_instr(32'h00000000, 0, 0, 4'b0000, 1'b0, o);
        chk("trap reached", o.trapped, 1);
        chk("trap no pc_wr", o.pc_wr_n, 0);
        nreq = 0; nill = 0; npc = 0;
        instr_ack = 1'b1;
        dmem_ack  = 1'b1;
        run = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (instr_req) nreq++;
            if (!illegal) nill++;
            if (pc_wr || reg_wr || dmem_rd || dmem_wr) npc++;
        end
        chk("trap no instr_req", nreq, 0);
        chk("trap illegal sticky (cycles low)", nill, 0);
        chk("trap strobes idle", npc, 0);
        instr_ack = 1'b0; dmem_ack = 1'b0; run = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk("reset exits trap", outs, 16'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
